output_packer: RTL and testbench

Parametrised successor to the PE output router. It captures one row of wide PE accumulator outputs, then requantises each lane to DATA_WIDTH with a programmable rounding right shift, optional ReLU and signed saturation. It packs the lanes into SPAD words and streams them with generated addresses under a ready/valid handshake. It sits between the systolic array outputs and the output scratchpad write port.

---
 rtl/output_packer.sv | 181 ++++++++++++++++++
 tb/tb_output_packer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/output_packer.sv
// Requantises one captured row of wide PE outputs into DATA_WIDTH lanes, packs them
// into scratchpad words and streams them with generated addresses under ready/valid.
module output_packer #(
  parameter int SPAD_ADDR_WIDTH = 8,
  parameter int SPAD_DATA_WIDTH = 16,
  parameter int ROUTER_COUNT    = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int SHIFT_WIDTH     = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_nrst,
  input  logic                                   i_en,
  input  logic [ROUTER_COUNT*2*DATA_WIDTH-1:0]   i_ifmap,
  input  logic [ROUTER_COUNT-1:0]                i_valid,
  input  logic [SHIFT_WIDTH-1:0]                 i_shift,
  input  logic                                   i_relu,
  input  logic [SPAD_ADDR_WIDTH-1:0]             i_base_addr,
  input  logic                                   i_ready,
  output logic [SPAD_DATA_WIDTH-1:0]             o_data_out,
  output logic [SPAD_ADDR_WIDTH-1:0]             o_addr,
  output logic                                   o_valid,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_sat
);

  localparam int PE_W       = 2 * DATA_WIDTH;
  localparam int EXT_W      = PE_W + 1;
  localparam int MEMBER_CNT = SPAD_DATA_WIDTH / DATA_WIDTH;
  localparam int GROUP_CNT  = (ROUTER_COUNT + MEMBER_CNT - 1) / MEMBER_CNT;
  localparam int CNT_W      = (GROUP_CNT > 1) ? $clog2(GROUP_CNT) : 1;
  localparam int SLOT_CNT   = 1 << CNT_W;
  localparam int PAD_CNT    = SLOT_CNT * MEMBER_CNT;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUP_CNT - 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_OUT, S_DONE} state_t;

  state_t                              state_reg, state_next;
  logic [CNT_W-1:0]                    count_reg, count_next;
  logic                                sat_reg, sat_next;
  logic                                capture;
  logic [ROUTER_COUNT*PE_W-1:0]        ifmap_reg;
  logic [ROUTER_COUNT-1:0]             valid_reg;
  logic [SHIFT_WIDTH-1:0]              shift_reg;
  logic                                relu_reg;
  logic [SPAD_ADDR_WIDTH-1:0]          base_reg;

  logic [PAD_CNT-1:0][DATA_WIDTH-1:0]  lane_q;
  logic [PAD_CNT-1:0]                  lane_valid;
  logic [PAD_CNT-1:0]                  lane_clip;
  logic [SLOT_CNT-1:0][SPAD_DATA_WIDTH-1:0] grp_word;
  logic [SLOT_CNT-1:0]                 grp_any;
  logic [SLOT_CNT-1:0]                 grp_clip;

  // Per-lane requantiser; lanes past ROUTER_COUNT are padding and stay zero.
  genvar gi, gj;
  generate
    for (gi = 0; gi < PAD_CNT; gi++) begin : g_lane
      if (gi < ROUTER_COUNT) begin : g_real
        logic [PE_W-1:0]         x;
        logic signed [EXT_W-1:0] ext, bias, sum, y;
        logic [DATA_WIDTH-1:0]   q;
        logic                    clip;

        assign x = ifmap_reg[gi*PE_W +: PE_W];

        always_comb begin
          ext  = {x[PE_W-1], x};
          bias = '0;
          if (shift_reg != '0) begin
            bias = EXT_W'(1) << (shift_reg - SHIFT_WIDTH'(1));
          end
          sum = ext + bias;
          y   = sum >>> shift_reg;
          if (relu_reg && y[EXT_W-1]) begin
            y = '0;
          end
          q    = y[DATA_WIDTH-1:0];
          clip = 1'b0;
          if (y > SAT_MAX) begin
            q    = SAT_MAX[DATA_WIDTH-1:0];
            clip = 1'b1;
          end else if (y < SAT_MIN) begin
            q    = SAT_MIN[DATA_WIDTH-1:0];
            clip = 1'b1;
          end
        end

        assign lane_q[gi]     = valid_reg[gi] ? q : '0;
        assign lane_valid[gi] = valid_reg[gi];
        assign lane_clip[gi]  = valid_reg[gi] & clip;
      end else begin : g_pad
        assign lane_q[gi]     = '0;
        assign lane_valid[gi] = 1'b0;
        assign lane_clip[gi]  = 1'b0;
      end
    end

    // Lane 0 of each group lands in the most significant slot of the word.
    for (gi = 0; gi < SLOT_CNT; gi++) begin : g_grp
      for (gj = 0; gj < MEMBER_CNT; gj++) begin : g_mem
        assign grp_word[gi][(MEMBER_CNT-1-gj)*DATA_WIDTH +: DATA_WIDTH] = lane_q[gi*MEMBER_CNT + gj];
      end
      assign grp_any[gi]  = |lane_valid[gi*MEMBER_CNT +: MEMBER_CNT];
      assign grp_clip[gi] = |lane_clip[gi*MEMBER_CNT +: MEMBER_CNT];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      sat_reg   <= 1'b0;
      ifmap_reg <= '0;
      valid_reg <= '0;
      shift_reg <= '0;
      relu_reg  <= 1'b0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      sat_reg   <= sat_next;
      if (capture) begin
        ifmap_reg <= i_ifmap;
        valid_reg <= i_valid;
        shift_reg <= i_shift;
        relu_reg  <= i_relu;
        base_reg  <= i_base_addr;
      end
    end
  end

  // o_valid depends only on state and captured lanes, never on i_ready.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    sat_next   = sat_reg;
    capture    = 1'b0;
    o_data_out = '0;
    o_addr     = '0;
    o_valid    = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_sat      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_en) begin
          state_next = S_OUT;
          count_next = '0;
          sat_next   = 1'b0;
          capture    = 1'b1;
        end
      end
      S_OUT: begin
        o_busy  = 1'b1;
        o_valid = grp_any[count_reg];
        if (grp_any[count_reg]) begin
          o_data_out = grp_word[count_reg];
          o_addr     = base_reg + SPAD_ADDR_WIDTH'(count_reg);
        end
        if (!grp_any[count_reg] || i_ready) begin
          sat_next   = sat_reg | grp_clip[count_reg];
          count_next = count_reg + CNT_W'(1);
          if (count_reg == LAST_GRP) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        o_busy     = 1'b1;
        o_done     = 1'b1;
        o_sat      = sat_reg;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_output_packer.sv
// Scoreboard bench for output_packer: stimulus queues expected words and done pulses,
// per-DUT monitors compare on the falling edge whenever a word or done is presented.
module tb_output_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, en, en3, relu, ready;
  logic [63:0] ifmap;
  logic [47:0] ifmap3;
  logic [3:0]  valid, shift;
  logic [2:0]  valid3;
  logic [7:0]  base;
  logic [15:0] data, data3;
  logic [7:0]  addr, addr3;
  logic        ovalid, busy, done, sat;
  logic        ovalid3, busy3, done3, sat3;

  output_packer dut (
    .i_clk(clk), .i_nrst(nrst), .i_en(en), .i_ifmap(ifmap), .i_valid(valid),
    .i_shift(shift), .i_relu(relu), .i_base_addr(base), .i_ready(ready),
    .o_data_out(data), .o_addr(addr), .o_valid(ovalid), .o_busy(busy),
    .o_done(done), .o_sat(sat)
  );

  output_packer #(.ROUTER_COUNT(3)) dut3 (
    .i_clk(clk), .i_nrst(nrst), .i_en(en3), .i_ifmap(ifmap3), .i_valid(valid3),
    .i_shift(shift), .i_relu(relu), .i_base_addr(base), .i_ready(ready),
    .o_data_out(data3), .o_addr(addr3), .o_valid(ovalid3), .o_busy(busy3),
    .o_done(done3), .o_sat(sat3)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [23:0] wq[$], wq3[$];
  int          dcyc[$], dcyc3[$];
  logic        dsat[$], dsat3[$];

  localparam logic [63:0] L_T1 = 64'h7FFF_FF80_0123_0010;
  localparam logic [63:0] L_T2 = 64'hFFC0_0018_FFF8_0123;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (ovalid) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word actual=addr 0x%0h data 0x%0h required=none", addr, data);
        end else begin
          chk("addr", addr, wq[0][23:16]);
          chk("data", data, wq[0][15:0]);
          if (ready) void'(wq.pop_front());
        end
      end else begin
        chk("idle_zero", {addr, data}, 0);
      end
      if (done) begin
        if (dcyc.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          chk("done_cycle", cyc, dcyc[0]);
          chk("sat", sat, dsat[0]);
          void'(dcyc.pop_front());
          void'(dsat.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      if (ovalid3) begin
        if (wq3.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word3 actual=addr 0x%0h data 0x%0h required=none", addr3, data3);
        end else begin
          chk("addr3", addr3, wq3[0][23:16]);
          chk("data3", data3, wq3[0][15:0]);
          if (ready) void'(wq3.pop_front());
        end
      end else begin
        chk("idle_zero3", {addr3, data3}, 0);
      end
      if (done3) begin
        if (dcyc3.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done3 actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          chk("done_cycle3", cyc, dcyc3[0]);
          chk("sat3", sat3, dsat3[0]);
          void'(dcyc3.pop_front());
          void'(dsat3.pop_front());
        end
      end
    end
  end

  // Called #1 after a rising edge; that edge's successor is edge 0, so cycle 1 sees cyc+1.
  task automatic go(input logic [63:0] l, input logic [3:0] v, input logic [3:0] s,
                    input logic r, input logic [7:0] b, input int dc, input logic st);
    ifmap = l; valid = v; shift = s; relu = r; base = b; en = 1'b1;
    dcyc.push_back(cyc + dc);
    dsat.push_back(st);
    @(posedge clk); #1;
    en = 1'b0;
    ifmap = 64'hA5A5_5A5A_C3C3_3C3C; valid = ~v; shift = ~s; relu = ~r; base = ~b;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
    chk("words_drained", wq.size() + wq3.size(), 0);
    chk("dones_seen", dcyc.size() + dcyc3.size(), 0);
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; en3 = 1'b0; ready = 1'b1; relu = 1'b0;
    ifmap = '0; ifmap3 = '0; valid = '0; valid3 = '0; shift = '0; base = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {ovalid, busy, done, sat, addr, data}, 0);
    chk("rst_outputs3", {ovalid3, busy3, done3, sat3, addr3, data3}, 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    wq.push_back({8'h10, 16'h107F}); wq.push_back({8'h11, 16'h807F});
    go(L_T1, 4'hF, 4'd0, 1'b0, 8'h10, 3, 1'b1);
    chk("busy_out", busy, 1);
    settle(4);

    wq.push_back({8'h20, 16'h1200}); wq.push_back({8'h21, 16'h02FC});
    go(L_T2, 4'hF, 4'd4, 1'b0, 8'h20, 3, 1'b0);
    settle(4);

    wq.push_back({8'h30, 16'h1200}); wq.push_back({8'h31, 16'h0200});
    go(L_T2, 4'hF, 4'd4, 1'b1, 8'h30, 3, 1'b0);
    settle(4);

    wq.push_back({8'h40, 16'h107F});
    go(L_T1, 4'b0011, 4'd0, 1'b0, 8'h40, 3, 1'b1);
    settle(4);

    go(L_T1, 4'b0000, 4'd0, 1'b0, 8'h50, 3, 1'b0);
    settle(4);

    ready = 1'b0;
    wq.push_back({8'h60, 16'h107F}); wq.push_back({8'h61, 16'h807F});
    go(L_T1, 4'hF, 4'd0, 1'b0, 8'h60, 6, 1'b1);
    @(posedge clk); #1; en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
    @(posedge clk); #1; ready = 1'b1;
    settle(3);

    wq.push_back({8'hFF, 16'h107F}); wq.push_back({8'h00, 16'h807F});
    go(L_T1, 4'hF, 4'd0, 1'b0, 8'hFF, 3, 1'b1);
    settle(4);

    wq3.push_back({8'h70, 16'h1020}); wq3.push_back({8'h71, 16'h3000});
    ifmap3 = 48'h0030_0020_0010; valid3 = 3'b111; shift = 4'd0; relu = 1'b0; base = 8'h70;
    en3 = 1'b1;
    dcyc3.push_back(cyc + 3);
    dsat3.push_back(1'b0);
    @(posedge clk); #1;
    en3 = 1'b0; ifmap3 = 48'hFFFF_FFFF_FFFF; base = 8'h00;
    settle(4);

    ready = 1'b0;
    wq.push_back({8'h80, 16'h107F});
    go(L_T1, 4'hF, 4'd0, 1'b0, 8'h80, 3, 1'b1);
    @(posedge clk); #1;
    nrst = 1'b0;
    #1;
    chk("abort_outputs", {ovalid, busy, done, sat, addr, data}, 0);
    wq.delete(); dcyc.delete(); dsat.delete();
    ready = 1'b1;
    @(negedge clk); #1;
    nrst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_done_after_abort", dcyc.size(), 0);
    chk("idle_after_abort", {ovalid, busy}, 0);

    wq.push_back({8'h90, 16'h107F}); wq.push_back({8'h91, 16'h807F});
    go(L_T1, 4'hF, 4'd0, 1'b0, 8'h90, 3, 1'b1);
    settle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
